// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between a fetch port and a data port.
// Define ARB_STARVE_GUARD_EN to bound how long fetch can wait behind data.
module mem_port_arbiter #(
   parameter int ADDR_W     = 14,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [31:0]       f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [31:0]       f_rdata,
   input  logic              d_req,
   input  logic [3:0]        d_we,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout,
   output logic              stall_f,
   output logic              stall_d
);

   typedef enum logic [1:0] {IDLE, FETCH, DATA_RD, DATA_WR} state_t;

   state_t      r_state;
   logic [31:0] r_fHold;
   logic [31:0] r_dHold;
   logic        w_forceFetch;
   logic        w_fGnt;
   logic        w_dGnt;
   logic        w_unused;

`ifdef ARB_STARVE_GUARD_EN
   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] r_starveCnt;

   assign w_forceFetch = f_req && (r_starveCnt == CNT_W'(STARVE_MAX));

   // Counts data grants that overtook a waiting fetch; any fetch grant or a withdrawn fetch request resets it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starveCnt <= '0;
      end else if (w_fGnt || !f_req) begin
         r_starveCnt <= '0;
      end else if (w_dGnt && (r_starveCnt != CNT_W'(STARVE_MAX))) begin
         r_starveCnt <= r_starveCnt + CNT_W'(1);
      end
   end
`else
   assign w_forceFetch = 1'b0;
`endif

   // Grants are masked by reset directly so nothing reaches memory while rst is held.
   assign w_dGnt = !rst && d_req && !w_forceFetch;
   assign w_fGnt = !rst && f_req && (!d_req || w_forceFetch);

   assign f_gnt    = w_fGnt;
   assign d_gnt    = w_dGnt;
   assign stall_f  = !rst && f_req && !w_fGnt;
   assign stall_d  = !rst && d_req && !w_dGnt;
   assign mem_en   = w_fGnt || w_dGnt;
   assign mem_we   = w_dGnt ? d_we : 4'b0000;
   assign mem_addr = w_dGnt ? d_addr[ADDR_W+1:2] : f_addr[ADDR_W+1:2];
   assign mem_din  = d_wdata;

   assign w_unused = ^{f_addr[1:0], f_addr[31:ADDR_W+2], d_addr[1:0], d_addr[31:ADDR_W+2]};

   assign f_rvalid = (r_state == FETCH);
   assign d_rvalid = (r_state == DATA_RD);
   assign f_rdata  = f_rvalid ? mem_dout : r_fHold;
   assign d_rdata  = d_rvalid ? mem_dout : r_dHold;

   // State records which access was issued last cycle, so it marks whose read data is on mem_dout now.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_fHold <= '0;
         r_dHold <= '0;
      end else begin
         if (r_state == FETCH) begin
            r_fHold <= mem_dout;
         end
         if (r_state == DATA_RD) begin
            r_dHold <= mem_dout;
         end
         if (w_fGnt) begin
            r_state <= FETCH;
         end else if (w_dGnt) begin
            r_state <= (d_we == 4'b0000) ? DATA_RD : DATA_WR;
         end else begin
            r_state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

   localparam int ADDR_W     = 14;
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              f_req;
   logic [31:0]       f_addr;
   logic              f_gnt;
   logic              f_rvalid;
   logic [31:0]       f_rdata;
   logic              d_req;
   logic [3:0]        d_we;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [31:0]       d_rdata;
   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_din;
   logic [31:0]       mem_dout;
   logic              stall_f;
   logic              stall_d;

   int cmpCount  = 0;
   int failCount = 0;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
      .stall_f(stall_f), .stall_d(stall_d)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge and are sampled 2 units later.
   task automatic applyStimulus(input logic fr, input logic [31:0] fa, input logic dr,
                                input logic [3:0] dwe, input logic [31:0] da,
                                input logic [31:0] dwd, input logic [31:0] md);
      f_req = fr; f_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; mem_dout = md;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(1'b1, 32'h40, 1'b1, 4'hF, 32'h80, 32'h55, 32'h77);
      #2;
      cmpCount++; if ({f_gnt, d_gnt, mem_en} !== 3'b000) begin failCount++; $display("[TB] FAIL reset_gnt got=%b want=000", {f_gnt, d_gnt, mem_en}); end
      cmpCount++; if (mem_we !== 4'h0) begin failCount++; $display("[TB] FAIL reset_we got=%h want=0", mem_we); end
      cmpCount++; if ({stall_f, stall_d} !== 2'b00) begin failCount++; $display("[TB] FAIL reset_stall got=%b want=00", {stall_f, stall_d}); end
      nextCycle();
      cmpCount++; if ({f_rvalid, d_rvalid} !== 2'b00) begin failCount++; $display("[TB] FAIL reset_rvalid got=%b want=00", {f_rvalid, d_rvalid}); end
      cmpCount++; if ({f_rdata, d_rdata} !== 64'h0) begin failCount++; $display("[TB] FAIL reset_rdata got=%h want=0", {f_rdata, d_rdata}); end
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      rst = 1'b0;
   endtask

   task automatic test_fetch();
      nextCycle();
      applyStimulus(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      #2;
      cmpCount++; if ({f_gnt, d_gnt, mem_en} !== 3'b101) begin failCount++; $display("[TB] FAIL fetch_gnt got=%b want=101", {f_gnt, d_gnt, mem_en}); end
      cmpCount++; if (mem_addr !== 14'd4) begin failCount++; $display("[TB] FAIL fetch_addr got=%0d want=4", mem_addr); end
      cmpCount++; if ({mem_we, stall_f} !== 5'b0) begin failCount++; $display("[TB] FAIL fetch_we_stall got=%b want=0", {mem_we, stall_f}); end
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF);
      #2;
      cmpCount++; if (f_rvalid !== 1'b1) begin failCount++; $display("[TB] FAIL fetch_rvalid got=%b want=1", f_rvalid); end
      cmpCount++; if (f_rdata !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL fetch_rdata got=%h want=deadbeef", f_rdata); end
      nextCycle();
      mem_dout = 32'h0BADF00D;
      #2;
      cmpCount++; if (f_rvalid !== 1'b0) begin failCount++; $display("[TB] FAIL fetch_rvalid_off got=%b want=0", f_rvalid); end
      cmpCount++; if (f_rdata !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL fetch_hold got=%h want=deadbeef", f_rdata); end
   endtask

   task automatic test_contention();
      nextCycle();
      applyStimulus(1'b1, 32'h40, 1'b1, 4'h0, 32'h20, 32'h0, 32'h0);
      #2;
      cmpCount++; if ({d_gnt, f_gnt, stall_f, stall_d} !== 4'b1010) begin failCount++; $display("[TB] FAIL cont_gnt got=%b want=1010", {d_gnt, f_gnt, stall_f, stall_d}); end
      cmpCount++; if (mem_addr !== 14'd8) begin failCount++; $display("[TB] FAIL cont_addr got=%0d want=8", mem_addr); end
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hCAFEF00D);
      #2;
      cmpCount++; if ({d_rvalid, f_rvalid} !== 2'b10) begin failCount++; $display("[TB] FAIL cont_rvalid got=%b want=10", {d_rvalid, f_rvalid}); end
      cmpCount++; if (d_rdata !== 32'hCAFEF00D) begin failCount++; $display("[TB] FAIL cont_rdata got=%h want=cafef00d", d_rdata); end
   endtask

   task automatic test_store();
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 4'b0011, 32'h8C, 32'h1234, 32'h0);
      #2;
      cmpCount++; if (mem_we !== 4'b0011) begin failCount++; $display("[TB] FAIL store_we got=%b want=0011", mem_we); end
      cmpCount++; if (mem_din !== 32'h1234) begin failCount++; $display("[TB] FAIL store_din got=%h want=1234", mem_din); end
      cmpCount++; if ({d_gnt, mem_en, mem_addr} !== {2'b11, 14'h23}) begin failCount++; $display("[TB] FAIL store_addr got=%h want=c023", {d_gnt, mem_en, mem_addr}); end
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h99999999);
      #2;
      cmpCount++; if ({d_rvalid, f_rvalid} !== 2'b00) begin failCount++; $display("[TB] FAIL store_rvalid got=%b want=00", {d_rvalid, f_rvalid}); end
      cmpCount++; if (d_rdata !== 32'hCAFEF00D) begin failCount++; $display("[TB] FAIL store_hold got=%h want=cafef00d", d_rdata); end
   endtask

   task automatic test_starvation();
      logic expF;
      for (int i = 0; i < 3 * (STARVE_MAX + 1); i++) begin
         nextCycle();
         applyStimulus(1'b1, 32'h100, 1'b1, 4'h0, 32'h200, 32'h0, 32'h0);
         #2;
`ifdef ARB_STARVE_GUARD_EN
         expF = ((i % (STARVE_MAX + 1)) == STARVE_MAX);
`else
         expF = 1'b0;
`endif
         cmpCount++;
         if ({f_gnt, d_gnt} !== {expF, !expF}) begin
            failCount++;
            $display("[TB] FAIL starve_cycle%0d got=%b want=%b", i, {f_gnt, d_gnt}, {expF, !expF});
         end
      end
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic test_reset_mid_read();
      nextCycle();
      applyStimulus(1'b1, 32'h44, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      nextCycle();
      applyStimulus(1'b1, 32'h48, 1'b1, 4'h0, 32'h4C, 32'h0, 32'h5A5A5A5A);
      rst = 1'b1;
      #2;
      cmpCount++; if ({f_rvalid, d_rvalid} !== 2'b00) begin failCount++; $display("[TB] FAIL midrst_rvalid got=%b want=00", {f_rvalid, d_rvalid}); end
      cmpCount++; if (f_rdata !== 32'h0) begin failCount++; $display("[TB] FAIL midrst_rdata got=%h want=0", f_rdata); end
      cmpCount++; if ({f_gnt, d_gnt, mem_en} !== 3'b000) begin failCount++; $display("[TB] FAIL midrst_gnt got=%b want=000", {f_gnt, d_gnt, mem_en}); end
      nextCycle();
      rst = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h5A5A5A5A);
      nextCycle();
      #2;
      cmpCount++; if ({f_rvalid, d_rvalid} !== 2'b00) begin failCount++; $display("[TB] FAIL postrst_rvalid got=%b want=00", {f_rvalid, d_rvalid}); end
   endtask

   task automatic test_back_to_back();
      nextCycle();
      applyStimulus(1'b1, 32'h60, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h64, 32'h0, 32'h11111111);
      #2;
      cmpCount++; if ({f_rvalid, d_rvalid, d_gnt} !== 3'b101) begin failCount++; $display("[TB] FAIL b2b_c1 got=%b want=101", {f_rvalid, d_rvalid, d_gnt}); end
      cmpCount++; if (f_rdata !== 32'h11111111) begin failCount++; $display("[TB] FAIL b2b_frdata1 got=%h want=11111111", f_rdata); end
      nextCycle();
      applyStimulus(1'b1, 32'h68, 1'b0, 4'h0, 32'h0, 32'h0, 32'h22222222);
      #2;
      cmpCount++; if ({f_rvalid, d_rvalid, f_gnt} !== 3'b011) begin failCount++; $display("[TB] FAIL b2b_c2 got=%b want=011", {f_rvalid, d_rvalid, f_gnt}); end
      cmpCount++; if (d_rdata !== 32'h22222222) begin failCount++; $display("[TB] FAIL b2b_drdata got=%h want=22222222", d_rdata); end
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h33333333);
      #2;
      cmpCount++; if ({f_rvalid, d_rvalid} !== 2'b10) begin failCount++; $display("[TB] FAIL b2b_c3 got=%b want=10", {f_rvalid, d_rvalid}); end
      cmpCount++; if (f_rdata !== 32'h33333333) begin failCount++; $display("[TB] FAIL b2b_frdata3 got=%h want=33333333", f_rdata); end
   endtask

   // Model: remembers only who was granted last cycle, the held read words and the data-overtake streak.
   task automatic test_random();
      int          lastKind = 0;
      int          streak   = 0;
      logic [31:0] fHold    = 32'h0;
      logic [31:0] dHold    = 32'h0;
      logic        fr, dr, forceF, eF, eD;
      logic [3:0]  dwe;
      logic [31:0] fa, da, dwd, md, eFR, eDR;
      logic [ADDR_W-1:0] eAddr;
      nextCycle();
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      for (int i = 0; i < 400; i++) begin
         nextCycle();
         fr  = ($urandom_range(0, 3) != 0);
         dr  = ($urandom_range(0, 2) != 0);
         dwe = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
         fa  = $urandom; da = $urandom; dwd = $urandom; md = $urandom;
         applyStimulus(fr, fa, dr, dwe, da, dwd, md);
`ifdef ARB_STARVE_GUARD_EN
         forceF = fr && (streak == STARVE_MAX);
`else
         forceF = 1'b0;
`endif
         eD    = dr && !forceF;
         eF    = fr && !eD;
         eAddr = eD ? da[ADDR_W+1:2] : fa[ADDR_W+1:2];
         eFR   = (lastKind == 1) ? md : fHold;
         eDR   = (lastKind == 2) ? md : dHold;
         #2;
         cmpCount++;
         if ({f_gnt, d_gnt, mem_en, stall_f, stall_d} !== {eF, eD, eF | eD, fr & !eF, dr & !eD}) begin
            failCount++;
            $display("[TB] FAIL rand%0d_gnt got=%b want=%b", i, {f_gnt, d_gnt, mem_en, stall_f, stall_d}, {eF, eD, eF | eD, fr & !eF, dr & !eD});
         end
         cmpCount++;
         if ((eF || eD) && ({mem_addr, mem_we, mem_din} !== {eAddr, eD ? dwe : 4'h0, dwd})) begin
            failCount++;
            $display("[TB] FAIL rand%0d_mem got=%h want=%h", i, {mem_addr, mem_we, mem_din}, {eAddr, eD ? dwe : 4'h0, dwd});
         end
         cmpCount++;
         if ({f_rvalid, d_rvalid, f_rdata, d_rdata} !== {lastKind == 1, lastKind == 2, eFR, eDR}) begin
            failCount++;
            $display("[TB] FAIL rand%0d_rd got=%h want=%h", i, {f_rvalid, d_rvalid, f_rdata, d_rdata}, {lastKind == 1, lastKind == 2, eFR, eDR});
         end
         fHold    = eFR;
         dHold    = eDR;
         lastKind = eF ? 1 : (eD ? ((dwe == 4'h0) ? 2 : 3) : 0);
         if (eF || !fr) streak = 0;
         else if (eD && streak < STARVE_MAX) streak++;
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_contention();
      test_store();
      test_starvation();
      test_reset_mid_read();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
      $finish;
   end

endmodule
